// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC generation, one-deep in-flight tracking toward a
// synchronous instruction memory, and a 2-entry fetch buffer feeding decode
// with a valid/ready handshake. Redirects flush every younger fetch.
module inst_fetch_unit #(
    parameter int                  AddrSize  = 32,
    parameter int                  Inst_Size = 32,
    parameter logic [AddrSize-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [AddrSize-1:0]  imem_addr,
    input  logic [Inst_Size-1:0] imem_inst,
    input  logic                 redirect_valid,
    input  logic [AddrSize-1:0]  redirect_pc,
    output logic                 if_valid,
    input  logic                 if_ready,
    output logic [Inst_Size-1:0] if_inst,
    output logic [AddrSize-1:0]  if_pc
);

    logic [AddrSize-1:0]  fetch_pc_q, fetch_pc_d;
    logic [AddrSize-1:0]  inflight_pc_q, inflight_pc_d;
    logic                 inflight_q, inflight_d;
    logic [1:0]           count_q, count_d;
    logic                 head_q, head_d;
    logic                 tail_q, tail_d;
    logic [Inst_Size-1:0] ent_inst_q [2];
    logic [Inst_Size-1:0] ent_inst_d [2];
    logic [AddrSize-1:0]  ent_pc_q   [2];
    logic [AddrSize-1:0]  ent_pc_d   [2];

    logic                 pop;
    logic                 capture;
    logic                 issue;
    logic [2:0]           credit;
    logic [AddrSize-1:0]  issue_pc;

    // Issue decision: a fetch goes out only when its return is guaranteed a buffer slot
    always_comb begin
        pop      = (count_q != 2'd0) && if_ready;
        credit   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue    = !rst && (redirect_valid || (credit < 3'd2));
        issue_pc = fetch_pc_q;
        if (rst) begin
            issue_pc = RESET_PC;
        end else if (redirect_valid) begin
            issue_pc = {redirect_pc[AddrSize-1:2], 2'b00};
        end
        imem_addr = {2'b00, issue_pc[AddrSize-1:2]};
        // Data returning in a redirect cycle belongs to the old stream
        capture   = inflight_q && !redirect_valid;
    end

    // Next-state for PC, in-flight tracking and the buffer; redirect outranks pop and capture
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        ent_inst_d    = ent_inst_q;
        ent_pc_d      = ent_pc_q;

        if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = issue_pc;
            fetch_pc_d    = issue_pc + AddrSize'(4);
        end

        if (redirect_valid) begin
            count_d = 2'd0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end else begin
            if (capture) begin
                ent_inst_d[tail_q] = imem_inst;
                ent_pc_d[tail_q]   = inflight_pc_q;
                tail_d             = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            count_d = count_q + {1'b0, capture} - {1'b0, pop};
        end
    end

    // State register with synchronous reset; entries cleared so outputs read zero after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            count_q       <= 2'd0;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                ent_inst_q[i] <= '0;
                ent_pc_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            ent_inst_q    <= ent_inst_d;
            ent_pc_q      <= ent_pc_d;
        end
    end

    // Decode-facing outputs come straight from the head entry
    always_comb begin
        if_valid = (count_q != 2'd0);
        if_inst  = ent_inst_q[head_q];
        if_pc    = ent_pc_q[head_q];
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: reset/stream, backpressure, redirects,
// PC wrap-around and reset in the middle of a stream.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_inst;
    logic [31:0] if_pc;

    logic [31:0] tb_mem [64];
    int          n_checks = 0;
    int          n_fail   = 0;

    inst_fetch_unit #(
        .AddrSize (32),
        .Inst_Size(32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_inst     (imem_inst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_inst       (if_inst),
        .if_pc         (if_pc)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory, one cycle latency
    always @(posedge clk) begin
        imem_inst <= tb_mem[imem_addr[5:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Move to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic settle();
        #1;
    endtask

    // Expect a valid head entry at the given byte PC carrying that word of memory
    task automatic check_out(input string tag, input logic [31:0] pc);
        logic [5:0] idx;
        idx = pc[7:2];
        check_eq({tag, " valid"}, {31'd0, if_valid}, 32'd1);
        check_eq({tag, " pc"}, if_pc, pc);
        check_eq({tag, " inst"}, if_inst, tb_mem[idx]);
    endtask

    // Two reset cycles; leaves the bench at the start of cycle 0 with rst low
    task automatic do_reset(input string tag);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        tick();
        settle();
        check_eq({tag, " rst valid"}, {31'd0, if_valid}, 32'd0);
        check_eq({tag, " rst pc"}, if_pc, 32'd0);
        check_eq({tag, " rst inst"}, if_inst, 32'd0);
        check_eq({tag, " rst addr"}, imem_addr, 32'd0);
        tick();
        rst = 1'b0;
    endtask

    // Startup timing: valid in cycle 2, then one instruction per cycle
    task automatic startup_check(input string tag);
        for (int k = 0; k < 6; k++) begin
            settle();
            check_eq($sformatf("%s c%0d addr", tag, k), imem_addr, 32'(k));
            if (k < 2) begin
                check_eq($sformatf("%s c%0d valid", tag, k), {31'd0, if_valid}, 32'd0);
            end else begin
                check_out($sformatf("%s c%0d", tag, k), 32'(4 * (k - 2)));
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) tb_mem[i] = 32'hC0DE_0000 | 32'(i);
        tb_mem[0]  = 32'h1111_1111;
        tb_mem[1]  = 32'h2222_2222;
        tb_mem[2]  = 32'h3333_3333;
        tb_mem[3]  = 32'h4444_4444;
        tb_mem[16] = 32'hAAAA_0013;

        // Reset then stream
        do_reset("s1");
        startup_check("s1");

        // Backpressure at if_pc=4 for five cycles
        do_reset("s2");
        run(3);
        if_ready = 1'b0;
        for (int c = 3; c < 8; c++) begin
            settle();
            check_out($sformatf("s2 stall c%0d", c), 32'd4);
            check_eq($sformatf("s2 stall c%0d addr", c), imem_addr, 32'd3);
            tick();
        end
        if_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            settle();
            check_out($sformatf("s2 drain %0d", j), 32'(4 + 4 * j));
            tick();
        end

        // Redirect while streaming: pop and capture coincide with the redirect
        do_reset("s3");
        run(4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        settle();
        check_eq("s3 R addr", imem_addr, 32'd16);
        tick();
        redirect_valid = 1'b0;
        settle();
        check_eq("s3 R+1 valid", {31'd0, if_valid}, 32'd0);
        check_eq("s3 R+1 addr", imem_addr, 32'd17);
        tick();
        for (int j = 0; j < 3; j++) begin
            settle();
            check_out($sformatf("s3 R+%0d", j + 2), 32'(32'h40 + 4 * j));
            tick();
        end

        // Redirect to unaligned target with a full buffer; pop in that cycle ignored
        do_reset("s4");
        run(3);
        if_ready = 1'b0;
        run(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        if_ready       = 1'b1;
        settle();
        check_eq("s4 R addr", imem_addr, 32'd16);
        tick();
        redirect_valid = 1'b0;
        settle();
        check_eq("s4 R+1 valid", {31'd0, if_valid}, 32'd0);
        tick();
        for (int j = 0; j < 2; j++) begin
            settle();
            check_out($sformatf("s4 R+%0d", j + 2), 32'(32'h40 + 4 * j));
            tick();
        end

        // PC wrap-around at the top of the address space
        do_reset("s5");
        run(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        settle();
        check_eq("s5 R addr", imem_addr, 32'h3FFF_FFFF);
        tick();
        redirect_valid = 1'b0;
        settle();
        check_eq("s5 R+1 valid", {31'd0, if_valid}, 32'd0);
        check_eq("s5 R+1 addr", imem_addr, 32'd0);
        tick();
        settle();
        check_out("s5 R+2", 32'hFFFF_FFFC);
        tick();
        settle();
        check_out("s5 R+3", 32'd0);
        tick();
        settle();
        check_out("s5 R+4", 32'd4);
        tick();

        // Reset mid-stream with a full buffer at if_pc=0x20
        do_reset("s6");
        run(10);
        if_ready = 1'b0;
        settle();
        check_out("s6 c10", 32'h20);
        tick();
        settle();
        check_out("s6 c11", 32'h20);
        check_eq("s6 c11 addr", imem_addr, 32'd10);
        do_reset("s6b");
        startup_check("s6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
PC generation and fetch-buffer stage directly upstream of the instruction memory (Inst_Mem).
- Drives the memory word address and captures the returned instruction one cycle later.
- Tags each instruction with its byte PC and presents it to decode through a 2-entry buffer with a valid/ready handshake.
- Accepts branch/jump redirects, which flush all younger fetches.

Parameters:
AddrSize, 32, width of the PC and of imem_addr
Inst_Size, 32, instruction width
RESET_PC, 32'h0000_0000, byte PC of the first fetch after reset (word aligned)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
imem_addr  output  AddrSize  word index to instruction memory, {2'b00, fetch_pc[AddrSize-1:2]}
imem_inst  input  Inst_Size  instruction word, valid the cycle after imem_addr is presented
redirect_valid  input  1  one-cycle pulse: change fetch stream
redirect_pc  input  AddrSize  byte target of redirect; bits [1:0] ignored (treated as 0)
if_valid  output  1  if_inst/if_pc hold a valid instruction
if_ready  input  1  decode accepts the head entry when if_valid && if_ready (pop)
if_inst  output  Inst_Size  head instruction
if_pc  output  AddrSize  byte PC of head instruction

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc <= RESET_PC; buffer count <= 0; in-flight flag <= 0.
  - if_valid=0, if_inst=0, if_pc=0.
  - imem_addr = RESET_PC>>2 combinationally.
  - No issue in a reset cycle.
- Memory model: synchronous read, 1-cycle latency, no enable. The word addressed in cycle N arrives on imem_inst in cycle N+1.
- Issue:
  - imem_addr = redirect_valid ? redirect_pc>>2 : fetch_pc>>2.
  - issue = !rst && (redirect_valid || (count + inflight - pop) < 2).
  - On issue: inflight <= 1, inflight_pc <= issued PC, fetch_pc <= issued PC + 4. Otherwise inflight <= 0 and fetch_pc holds.
- Capture: if inflight==1 and not killed, {imem_inst, inflight_pc} is written at the tail in that cycle. The credit rule guarantees a free entry, so no overflow is possible.
- Buffer:
  - 2 entries; 1-bit head/tail pointers that wrap 1->0; count 0..2.
  - Write and pop in the same cycle: count unchanged, both pointers advance.
  - if_valid = (count != 0). Outputs are driven straight from the head entry and stay stable while if_valid && !if_ready.
- Latency and throughput:
  - First instruction after reset: issued cycle 0, captured cycle 1, if_valid=1 in cycle 2.
  - Sustained 1 instruction/cycle while if_ready=1.
- Backpressure: with if_ready=0, at most 2 instructions are outstanding (buffered plus in flight). fetch_pc stalls with no loss or duplication of PCs.
- Redirect (redirect_valid=1 in cycle R):
  - count <= 0 and pointers <= 0. Any pop in cycle R is ignored.
  - Data returning in cycle R (issued at R-1) is discarded.
  - redirect_pc is issued in cycle R and fetch_pc <= redirect_pc + 4.
  - Target is captured in R+1 and if_valid=1 with if_pc=redirect_pc in R+2.
  - Redirect has priority over stall, pop and capture.
- Wrap-around: PC arithmetic is modulo 2^AddrSize, so 0xFFFF_FFFC + 4 = 0.
- Reset mid-operation: wins over redirect and handshake. Buffered and in-flight data are dropped, and the next cycle behaves as after the first reset.

Test Plan:
- Reset then stream: mem[0..3]=0x11111111,0x22222222,0x33333333,0x44444444, rst 1 for 2 cycles, if_ready=1 -> if_valid rises 2 cycles after rst falls; (if_pc,if_inst) = (0,0x11111111),(4,0x22222222),(8,0x33333333),(12,0x44444444) on consecutive cycles; imem_addr = 0,1,2,3...
- Backpressure: stream, then if_ready=0 for 5 cycles at if_pc=4 -> if_pc/if_inst held at 4/0x22222222; count reaches 2, imem_addr frozen; on release, PCs 4,8,12 follow with no gap, loss or duplicate.
- Redirect while streaming: redirect_valid with redirect_pc=0x40 (mem[16]=0xAAAA0013) at cycle R -> imem_addr=16 in R; if_valid=0 in R+1; if_pc=0x40, if_inst=0xAAAA0013 in R+2; no instruction from the old stream appears after R.
- Redirect with full buffer and if_ready=0, redirect_pc=0x43 -> buffer flushed, pop ignored, next if_pc=0x40.
- Redirect plus pop plus capture in the same cycle -> only the redirect takes effect; count 0 the next cycle.
- Reset mid-stream at if_pc=0x20 with count=2 -> if_valid=0 the cycle after; restart from RESET_PC with the same timing as the first scenario.
